// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared constants and hex-to-segment table for the seven-segment scanner
package seg_disp_pkg;

    localparam int MAX_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF = 8'hFF;

    // Active-low segment code, bit order {G,F,E,D,C,B,A}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_scan_display_decode.sv
// rtl/seg_scan_display_decode.sv - combinational hex nibble to active-low seven-segment code
module hex7seg_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_code
);

    assign seg_code = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed seven-segment scanner with frame snapshot, dead-time, blink and leading-zero blanking
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 8192,
    parameter int DEAD_CYC   = 16,
    parameter int BLINK_LOG2 = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_suppress,
    input  logic                    hold,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [7:0]              an,
    output logic                    frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]             presc;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   snap;
    logic [BLINK_LOG2:0]       blink_cnt;
    logic                      slot_end;
    logic                      frame_wrap;
    logic                      dark;
    logic                      zero_above;
    logic [2:0]                sel;
    logic [3:0]                nibble;
    logic [6:0]                seg_code;
    logic [4*MAX_DIGITS-1:0]   snap_pad;
    logic [MAX_DIGITS-1:0]     dp_pad;
    logic [MAX_DIGITS-1:0]     en_pad;
    logic [MAX_DIGITS-1:0]     blink_pad;
    logic [MAX_DIGITS-1:0]     lead_zero;

    assign slot_end   = (presc == PRESC_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);

    // Zero-padded to the full 8-digit width so idx never selects past the real digits
    assign snap_pad  = (4*MAX_DIGITS)'(snap);
    assign dp_pad    = MAX_DIGITS'(dp_in);
    assign en_pad    = MAX_DIGITS'(digit_en);
    assign blink_pad = MAX_DIGITS'(blink_mask);
    assign sel       = 3'(idx);
    assign nibble    = snap_pad[4*sel +: 4];

    always_comb begin
        lead_zero  = '0;
        zero_above = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above & (snap_pad[4*i +: 4] == 4'h0);
            lead_zero[i] = zero_above && (i != 0);
        end
    end

    assign dark = (presc < DEAD_END) || !en_pad[sel]
                  || (blink_pad[sel] && blink_cnt[BLINK_LOG2])
                  || (lz_suppress && lead_zero[sel]);

    hex7seg_decode u_decode (
        .nibble   (nibble),
        .seg_code (seg_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            idx       <= '0;
            snap      <= '0;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (slot_end) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (frame_wrap && !hold) begin
                snap <= value;
            end
        end
    end

    // Outputs lag the scan state by one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (dark) begin
                an  <= AN_OFF;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= ~(MAX_DIGITS'(1) << sel);
                seg <= seg_code;
                dp  <= ~dp_pad[sel];
            end
        end
    end

endmodule
